// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and request record for the data-memory stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Request fields captured at acceptance (the address is held separately
    // because its width is a module parameter).
    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] data;
    } req_t;

    // Reserved size behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == SZ_WORD || size == SZ_RSVD) begin
            return offset != 2'b00;
        end
        return (size == SZ_HALF) ? offset[0] : 1'b0;
    endfunction

endpackage

// File: rtl/mem_moc_unit_if.sv
// MFA/MOC request/response bundle between control/datapath and the memory stage.
// Latency: none (wires only).
// Backpressure: master holds mfa until moc is seen, then drops it to release the slave.
// Ports: mfa/rw/size/sign_ext/addr/data_in from master; data_out/moc/busy/err from slave.
interface mem_moc_unit_if #(
    parameter int ADDR_W = 9
);
    logic              mfa;
    logic              rw;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              moc;
    logic              busy;
    logic              err;

    modport master (
        output mfa, rw, size, sign_ext, addr, data_in,
        input  data_out, moc, busy, err
    );

    modport slave (
        input  mfa, rw, size, sign_ext, addr, data_in,
        output data_out, moc, busy, err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: read extraction/extension and write byte-enable generation.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rd_lanes (lane 0 = byte at aligned base = word MSB), offset, size, sign_ext,
//        wr_data in; rd_data, wr_be, wr_lanes, misalign out.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0][7:0] rd_lanes,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic [3:0]      wr_be,
    output logic [3:0][7:0] wr_lanes,
    output logic            misalign
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        rd_data  = '0;
        wr_be    = '0;
        wr_lanes = '0;
        sel_b    = rd_lanes[offset];
        sel_h    = offset[1] ? {rd_lanes[2], rd_lanes[3]} : {rd_lanes[0], rd_lanes[1]};
        misalign = is_misaligned(size, offset);

        case (size)
            SZ_BYTE: begin
                rd_data        = {{24{sign_ext & sel_b[7]}}, sel_b};
                wr_be[offset]  = 1'b1;
                wr_lanes       = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                rd_data  = {{16{sign_ext & sel_h[15]}}, sel_h};
                wr_be    = offset[1] ? 4'b1100 : 4'b0011;
                // MSB byte goes to the lower-numbered (lower-address) lane.
                wr_lanes = {2{wr_data[7:0], wr_data[15:8]}};
            end
            default: begin
                rd_data  = {rd_lanes[0], rd_lanes[1], rd_lanes[2], rd_lanes[3]};
                wr_be    = 4'b1111;
                wr_lanes = {wr_data[7:0], wr_data[15:8], wr_data[23:16], wr_data[31:24]};
            end
        endcase

        // A misaligned access must leave memory untouched.
        if (misalign) begin
            wr_be = '0;
        end
    end

endmodule

// File: rtl/mem_moc_unit.sv
// Data-memory stage: byte/half/word big-endian RAM access with MFA/MOC completion.
// Latency: moc rises LATENCY edges after the accepting edge; held until mfa drops.
// Backpressure: requests accepted only in IDLE; busy is high in ACCESS and DONE.
// Ports: clk, reset (sync, active-high), bus (slave side of mem_moc_unit_if).
module mem_moc_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_moc_unit_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q, dout_d;

    logic [7:0]        mem_q [0:(1<<ADDR_W)-1];

    logic [3:0][7:0]   rd_lanes;
    logic [3:0][7:0]   wr_lanes;
    logic [3:0]        wr_be;
    logic [31:0]       rd_data;
    logic              misalign;
    logic              complete;

    // All four bytes of the aligned word containing the latched address.
    always_comb begin
        rd_lanes = '0;
        for (int k = 0; k < 4; k++) begin
            rd_lanes[k] = mem_q[{addr_q[ADDR_W-1:2], 2'(k)}];
        end
    end

    mem_lane_align u_lane_align (
        .rd_lanes (rd_lanes),
        .offset   (addr_q[1:0]),
        .size     (req_q.size),
        .sign_ext (req_q.sign_ext),
        .wr_data  (req_q.data),
        .rd_data  (rd_data),
        .wr_be    (wr_be),
        .wr_lanes (wr_lanes),
        .misalign (misalign)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        moc_d    = moc_q;
        err_d    = err_q;
        dout_d   = dout_q;
        complete = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mfa) begin
                    req_d   = '{rw: bus.rw, size: bus.size, sign_ext: bus.sign_ext, data: bus.data_in};
                    addr_d  = bus.addr;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    moc_d    = 1'b1;
                    err_d    = misalign;
                    if (req_q.rw == RW_READ && !misalign) begin
                        dout_d = rd_data;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Waiting here for mfa to drop stops a held strobe re-triggering.
                if (!bus.mfa) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // RAM is not reset; a reset on the completing edge abandons the write.
    always_ff @(posedge clk) begin
        if (!reset && complete && req_q.rw == RW_WRITE) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem_q[{addr_q[ADDR_W-1:2], 2'(k)}] <= wr_lanes[k];
                end
            end
        end
    end

    assign bus.data_out = dout_q;
    assign bus.moc      = moc_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_moc_unit.sv
module tb_mem_moc_unit;

    localparam int AW    = 9;
    localparam int NDUT  = 3;
    localparam int TRACE = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mfa = 1'b0;
    logic          rw = 1'b0;
    logic          sign_ext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;

    logic [NDUT-1:0]       moc_w, busy_w, err_w;
    logic [NDUT-1:0][31:0] dout_w;

    int n_vec = 0;
    int n_bad = 0;

    // Reference memory and expected data_out (identical for every build).
    logic [7:0]  mm [512];
    logic [31:0] dout_m = 32'h0;

    always #5 clk = ~clk;

    // Three builds driven with identical stimulus: LATENCY 2, 1 and 5.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        mem_moc_unit_if #(.ADDR_W(AW)) bus ();
        assign bus.mfa      = mfa;
        assign bus.rw       = rw;
        assign bus.size     = size;
        assign bus.sign_ext = sign_ext;
        assign bus.addr     = addr;
        assign bus.data_in  = data_in;
        assign moc_w[g]     = bus.moc;
        assign busy_w[g]    = bus.busy;
        assign err_w[g]     = bus.err;
        assign dout_w[g]    = bus.data_out;
        mem_moc_unit #(.ADDR_W(AW), .LATENCY(L)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic mis_of(input logic [1:0] sz, input int a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] read_model(input logic [1:0] sz, input logic se, input int a);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        v  = 32'h0;
        for (int k = 0; k < nb; k++) v = (v << 8) | 32'(mm[(a + k) % 512]);
        if (se && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic write_model(input logic [1:0] sz, input int a, input logic [31:0] d);
        int nb;
        logic [31:0] sh;
        nb = nbytes(sz);
        for (int k = 0; k < nb; k++) begin
            sh = d >> (8 * (nb - 1 - k));
            mm[(a + k) % 512] = sh[7:0];
        end
    endtask

    // Called at a negedge. mfa is high for edges 0..hold-1 relative to acceptance.
    task automatic run_op(input logic r, input logic [1:0] sz, input logic se,
                          input int a, input logic [31:0] d, input int hold);
        logic m;
        logic mexp;
        int   l;
        m = mis_of(sz, a);
        if (!m) begin
            if (r) dout_m = read_model(sz, se, a);
            else   write_model(sz, a, d);
        end
        rw = r; size = sz; sign_ext = se; addr = AW'(a); data_in = d; mfa = 1'b1;
        for (int c = 0; c < TRACE; c++) begin
            @(posedge clk);
            @(negedge clk);
            // Inputs other than mfa must be ignored once the request is latched.
            rw = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
            addr = AW'($urandom); data_in = $urandom;
            if (c + 1 >= hold) mfa = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                l    = lat_of(i);
                mexp = (c == l) || (c > l && c < hold);
                chk($sformatf("moc L%0d c%0d", l, c), 32'(moc_w[i]), 32'(mexp));
                chk($sformatf("busy L%0d c%0d", l, c), 32'(busy_w[i]), 32'((c < l) || mexp));
                if (mexp) chk($sformatf("err L%0d c%0d", l, c), 32'(err_w[i]), 32'(m));
            end
        end
        for (int i = 0; i < NDUT; i++) chk($sformatf("dout L%0d", lat_of(i)), dout_w[i], dout_m);
    endtask

    task automatic chk_all_dout(input string tag, input logic [31:0] exp);
        for (int i = 0; i < NDUT; i++) chk($sformatf("%s L%0d", tag, lat_of(i)), dout_w[i], exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s moc L%0d", tag, lat_of(i)), 32'(moc_w[i]), 32'h0);
            chk($sformatf("%s busy L%0d", tag, lat_of(i)), 32'(busy_w[i]), 32'h0);
            chk($sformatf("%s err L%0d", tag, lat_of(i)), 32'(err_w[i]), 32'h0);
            chk($sformatf("%s dout L%0d", tag, lat_of(i)), dout_w[i], 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 512; k++) mm[k] = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic word write/read, sub-word reads and extension.
        run_op(1'b0, 2'b10, 1'b0, 'h010, 32'hDEADBEEF, 1);
        run_op(1'b1, 2'b10, 1'b0, 'h010, 32'h0, 1);
        chk_all_dout("word_rd", 32'hDEADBEEF);
        run_op(1'b1, 2'b00, 1'b0, 'h011, 32'h0, 1);
        chk_all_dout("byte_zx", 32'h000000AD);
        run_op(1'b1, 2'b00, 1'b1, 'h012, 32'h0, 1);
        chk_all_dout("byte_sx", 32'hFFFFFFBE);
        run_op(1'b1, 2'b01, 1'b0, 'h012, 32'h0, 1);
        chk_all_dout("half_zx", 32'h0000BEEF);

        // Misaligned word write: err with moc, no memory change.
        run_op(1'b0, 2'b10, 1'b0, 'h013, 32'h12345678, 1);
        run_op(1'b1, 2'b10, 1'b0, 'h010, 32'h0, 1);
        chk_all_dout("after_mis", 32'hDEADBEEF);

        // Held strobe: one access, moc held until mfa drops.
        run_op(1'b1, 2'b01, 1'b1, 'h010, 32'h0, 6);
        chk_all_dout("held_rd", 32'hFFFFDEAD);

        // Reset in ACCESS abandons a write.
        run_op(1'b0, 2'b10, 1'b0, 'h020, 32'hCAFEF00D, 1);
        rw = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = AW'('h020); data_in = 32'h11111111;
        mfa = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mfa = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dout_m = 32'h0;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        run_op(1'b1, 2'b10, 1'b0, 'h020, 32'h0, 1);
        chk_all_dout("old_contents", 32'hCAFEF00D);

        // Random traffic in a pre-filled window.
        for (int a = 'h40; a < 'h80; a += 4) run_op(1'b0, 2'b10, 1'b0, a, $urandom, 1);
        for (int n = 0; n < 80; n++) begin
            run_op(1'($urandom), 2'($urandom), 1'($urandom),
                   int'($urandom_range('h40, 'h7F)), $urandom, int'($urandom_range(1, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
